// File: rtl/lzw_out_packer.sv
// LSB-first packer turning CODE_W-bit LZW codes into a byte stream with flush/close support.
// Latency: a push is visible as ByteValid the next cycle; Ready drops while any full byte (or flush byte) is pending.
module lzw_out_packer #(
    parameter int CODE_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RequestOutBuffer,
    input  logic              CloseBuffer,
    input  logic [CODE_W-1:0] Code,
    output logic              Ready,
    output logic [7:0]        ByteOut,
    output logic              ByteValid,
    input  logic              ByteAccept,
    output logic              Closed,
    output logic              Overrun,
    output logic [15:0]       ByteCount
);

    localparam int OUT_W = 8;
    localparam int ACC_W = CODE_W + 7;
    localparam int CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t             state, stateNext;
    logic [ACC_W-1:0]   acc, accNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic               pushFire, closeFire, popFire;

    assign Ready     = (state == RUN) && (cnt < CNT_W'(OUT_W));
    assign ByteValid = (cnt >= CNT_W'(OUT_W)) || ((state == FLUSH) && (cnt != '0));
    assign ByteOut   = acc[OUT_W-1:0];
    assign Closed    = (state == DONE);

    assign pushFire  = RequestOutBuffer && Ready;
    assign closeFire = CloseBuffer && Ready;
    assign popFire   = ByteValid && ByteAccept;

    // Push and pop never coincide: Ready and ByteValid are mutually exclusive.
    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        if (pushFire) begin
            accNext = acc | (ACC_W'(Code) << cnt);
            cntNext = cnt + CNT_W'(CODE_W);
        end
        if (popFire) begin
            accNext = acc >> OUT_W;
            cntNext = (cnt >= CNT_W'(OUT_W)) ? cnt - CNT_W'(OUT_W) : '0;
        end
        unique case (state)
            RUN: begin
                if (closeFire)
                    stateNext = FLUSH;
            end
            FLUSH: begin
                // Leaving on the final accept edge makes Closed land right after that byte.
                if ((cnt == '0) || (popFire && (cnt <= CNT_W'(OUT_W))))
                    stateNext = DONE;
            end
            DONE: begin
                stateNext = RUN;
                accNext   = '0;
                cntNext   = '0;
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            acc       <= '0;
            cnt       <= '0;
            Overrun   <= 1'b0;
            ByteCount <= '0;
        end else begin
            state <= stateNext;
            acc   <= accNext;
            cnt   <= cntNext;
            if ((RequestOutBuffer || CloseBuffer) && !Ready)
                Overrun <= 1'b1;
            if (popFire)
                ByteCount <= ByteCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_lzw_out_packer.sv
// Directed bench for lzw_out_packer: expected bytes go into a queue, a negedge monitor checks them.
module tb_lzw_out_packer;

    localparam int CODE_W = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              RequestOutBuffer = 1'b0;
    logic              CloseBuffer = 1'b0;
    logic [CODE_W-1:0] Code = '0;
    logic              Ready;
    logic [7:0]        ByteOut;
    logic              ByteValid;
    logic              ByteAccept = 1'b1;
    logic              Closed;
    logic              Overrun;
    logic [15:0]       ByteCount;

    int checks = 0;
    int failures = 0;
    int closedCnt = 0;
    logic [7:0] expQ[$];

    lzw_out_packer #(.CODE_W(CODE_W)) dut (
        .clk(clk), .reset(reset),
        .RequestOutBuffer(RequestOutBuffer), .CloseBuffer(CloseBuffer), .Code(Code),
        .Ready(Ready), .ByteOut(ByteOut), .ByteValid(ByteValid), .ByteAccept(ByteAccept),
        .Closed(Closed), .Overrun(Overrun), .ByteCount(ByteCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (Closed)
                closedCnt++;
            if (ByteValid && ByteAccept) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no byte at %0t", ByteOut, $time);
                end else begin
                    check("byte", {24'd0, ByteOut}, {24'd0, expQ.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !Ready; i++)
            tick();
        check("wait_ready", {31'd0, Ready}, 32'd1);
    endtask

    task automatic wait_closed();
        int c0 = closedCnt;
        for (int i = 0; i < 60 && closedCnt == c0; i++)
            tick();
        check("closed_pulse_count", closedCnt - c0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && expQ.size() != 0; i++)
            tick();
        check("drain", expQ.size(), 32'd0);
    endtask

    task automatic push(input logic [CODE_W-1:0] c, input logic cl);
        wait_ready();
        Code = c;
        RequestOutBuffer = 1'b1;
        CloseBuffer = cl;
        tick();
        RequestOutBuffer = 1'b0;
        CloseBuffer = 1'b0;
    endtask

    task automatic close();
        wait_ready();
        CloseBuffer = 1'b1;
        tick();
        CloseBuffer = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'd0, Ready}, 32'd1);
        check({tag, "_bytevalid"}, {31'd0, ByteValid}, 32'd0);
        check({tag, "_byteout"}, {24'd0, ByteOut}, 32'd0);
        check({tag, "_closed"}, {31'd0, Closed}, 32'd0);
        check({tag, "_overrun"}, {31'd0, Overrun}, 32'd0);
        check({tag, "_bytecount"}, {16'd0, ByteCount}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("reset");

        // Two codes then close: 0x041 | 0x042<<9 -> 41 84 00
        expQ.push_back(8'h41);
        expQ.push_back(8'h84);
        expQ.push_back(8'h00);
        push(9'h041, 1'b0);
        push(9'h042, 1'b0);
        close();
        wait_closed();
        wait_drain();
        check("bytecount_t1", {16'd0, ByteCount}, 32'd3);

        // Eight all-ones codes fill exactly 9 bytes; close then has nothing to pad.
        for (int i = 0; i < 9; i++)
            expQ.push_back(8'hFF);
        for (int i = 0; i < 8; i++)
            push(9'h1FF, 1'b0);
        wait_drain();
        wait_ready();
        close();
        check("aligned_closed_c1", {31'd0, Closed}, 32'd0);
        check("aligned_ready_c1", {31'd0, Ready}, 32'd0);
        tick();
        check("aligned_closed_c2", {31'd0, Closed}, 32'd1);
        tick();
        check("aligned_closed_c3", {31'd0, Closed}, 32'd0);
        check("aligned_ready_c3", {31'd0, Ready}, 32'd1);
        check("bytecount_t2", {16'd0, ByteCount}, 32'd12);

        // Push and close together from empty.
        expQ.push_back(8'h01);
        expQ.push_back(8'h01);
        push(9'h101, 1'b1);
        check("simul_closed_c1", {31'd0, Closed}, 32'd0);
        check("simul_valid_c1", {31'd0, ByteValid}, 32'd1);
        tick();
        check("simul_closed_c2", {31'd0, Closed}, 32'd0);
        tick();
        check("simul_closed_c3", {31'd0, Closed}, 32'd1);
        wait_drain();
        check("bytecount_t3", {16'd0, ByteCount}, 32'd14);

        // Backpressure holds the byte stable and keeps Ready low.
        tick();
        ByteAccept = 1'b0;
        expQ.push_back(8'hAA);
        push(9'h0AA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, ByteValid}, 32'd1);
            check("bp_byteout", {24'd0, ByteOut}, 32'hAA);
            check("bp_ready", {31'd0, Ready}, 32'd0);
            tick();
        end
        ByteAccept = 1'b1;
        tick();
        check("bp_ready_after", {31'd0, Ready}, 32'd1);
        expQ.push_back(8'h00);
        close();
        wait_closed();
        wait_drain();
        check("bytecount_t4", {16'd0, ByteCount}, 32'd16);

        // Push while Ready is low is dropped and flags Overrun.
        tick();
        ByteAccept = 1'b0;
        expQ.push_back(8'hAA);
        push(9'h0AA, 1'b0);
        check("ovr_before", {31'd0, Overrun}, 32'd0);
        Code = 9'h155;
        RequestOutBuffer = 1'b1;
        tick();
        RequestOutBuffer = 1'b0;
        check("ovr_set", {31'd0, Overrun}, 32'd1);
        check("ovr_byte_held", {24'd0, ByteOut}, 32'hAA);
        ByteAccept = 1'b1;
        expQ.push_back(8'h00);
        close();
        wait_closed();
        wait_drain();
        check("ovr_sticky", {31'd0, Overrun}, 32'd1);
        check("bytecount_t5", {16'd0, ByteCount}, 32'd18);

        // Reset during FLUSH with two bytes pending discards them silently.
        expQ.push_back(8'hAA);
        push(9'h0AA, 1'b0);
        wait_drain();
        ByteAccept = 1'b0;
        push(9'h155, 1'b1);
        tick();
        check("flush_pending", {31'd0, ByteValid}, 32'd1);
        check("flush_ready", {31'd0, Ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("midreset");
        ByteAccept = 1'b1;
        c0 = closedCnt;
        for (int i = 0; i < 10; i++)
            tick();
        check("midreset_no_closed", closedCnt - c0, 32'd0);
        check("midreset_no_bytes", {16'd0, ByteCount}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
